// File: rtl/bullet_hit_scanner_pkg.sv
// Shared definitions for the bullet hit scanner: colour codes, word field
// positions and scan state encoding.
package bullet_hit_scanner_pkg;

    localparam int IDX_W = 3;

    localparam logic [2:0] COLOR_WHITE = 3'b000;
    localparam logic [2:0] COLOR_GREEN = 3'b001;
    localparam logic [2:0] COLOR_BLUE  = 3'b010;

    // Position words carry x in the high byte; size words carry width there.
    localparam int X_HI = 15;
    localparam int X_LO = 8;
    localparam int Y_HI = 7;
    localparam int Y_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } scan_state_e;

endpackage

// File: rtl/bullet_hit_scanner_box_overlap.sv
// Combinational axis-aligned box overlap test on 8-bit coordinates.
// Also used by the VGA side, so it carries no scanner-specific logic.
module box_overlap
    import bullet_hit_scanner_pkg::*;
(
    input  logic [15:0] a_pos_i,
    input  logic [15:0] a_size_i,
    input  logic [15:0] b_pos_i,
    input  logic [15:0] b_size_i,
    output logic        overlap_o
);

    logic [7:0] ax, ay, aw, ah;
    logic [7:0] bx, by, bw, bh;
    logic [8:0] axEnd, ayEnd, bxEnd, byEnd;
    logic       nonEmpty;

    assign ax = a_pos_i[X_HI:X_LO];
    assign ay = a_pos_i[Y_HI:Y_LO];
    assign aw = a_size_i[X_HI:X_LO];
    assign ah = a_size_i[Y_HI:Y_LO];
    assign bx = b_pos_i[X_HI:X_LO];
    assign by = b_pos_i[Y_HI:Y_LO];
    assign bw = b_size_i[X_HI:X_LO];
    assign bh = b_size_i[Y_HI:Y_LO];

    // Far edges are 9 bits wide so boxes near 0xFF do not wrap to the left side.
    assign axEnd = {1'b0, ax} + {1'b0, aw};
    assign ayEnd = {1'b0, ay} + {1'b0, ah};
    assign bxEnd = {1'b0, bx} + {1'b0, bw};
    assign byEnd = {1'b0, by} + {1'b0, bh};

    // A degenerate box can still satisfy the strict inequalities, so exclude it.
    assign nonEmpty = (aw != 8'd0) && (ah != 8'd0) && (bw != 8'd0) && (bh != 8'd0);

    assign overlap_o = nonEmpty
                     && ({1'b0, bx} < axEnd) && ({1'b0, ax} < bxEnd)
                     && ({1'b0, by} < ayEnd) && ({1'b0, ay} < byEnd);

endmodule

// File: rtl/bullet_hit_scanner.sv
// Walks the bullet table once per frame, collects damage/heal events against
// the player box and applies them to HP with an invincibility cooldown.
module bullet_hit_scanner
    import bullet_hit_scanner_pkg::*;
#(
    parameter int NUM_SLOTS    = 8,
    parameter int HP_MAX       = 20,
    parameter int DAMAGE       = 4,
    parameter int HEAL         = 1,
    parameter int IFRAME_SCANS = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      player_pos,
    input  logic [15:0]      player_size,
    input  logic             player_moving,
    output logic [IDX_W-1:0] index,
    input  logic [15:0]      bullet_position,
    input  logic [15:0]      bullet_size,
    input  logic [2:0]       bullet_color,
    input  logic             bullet_is_render,
    output logic [7:0]       hp,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             healed,
    output logic             dead
);

    localparam int                CD_W      = $clog2(IFRAME_SCANS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [7:0]        HP_MAX8   = 8'(HP_MAX);
    localparam logic [7:0]        DAMAGE8   = 8'(DAMAGE);
    localparam logic [7:0]        HEAL8     = 8'(HEAL);
    localparam logic [CD_W-1:0]   CD_RELOAD = CD_W'(IFRAME_SCANS);
    localparam logic [CD_W-1:0]   CD_ONE    = CD_W'(1);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       hp_q, hp_d;
    logic [CD_W-1:0]  cooldown_q, cooldown_d;
    logic             dmgFlag_q, dmgFlag_d;
    logic             healFlag_q, healFlag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic             healed_q, healed_d;
    logic             dead_q, dead_d;

    logic slotOverlap;
    logic slotTouched;
    logic slotDamages;
    logic slotHeals;

    box_overlap u_box_overlap (
        .a_pos_i   (player_pos),
        .a_size_i  (player_size),
        .b_pos_i   (bullet_position),
        .b_size_i  (bullet_size),
        .overlap_o (slotOverlap)
    );

    // Blue bullets only hurt a player who moved this frame.
    assign slotTouched = bullet_is_render && slotOverlap;
    assign slotDamages = slotTouched && ((bullet_color == COLOR_WHITE)
                      || ((bullet_color == COLOR_BLUE) && player_moving));
    assign slotHeals   = slotTouched && (bullet_color == COLOR_GREEN);

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        hp_d       = hp_q;
        cooldown_d = cooldown_q;
        dmgFlag_d  = dmgFlag_q;
        healFlag_d = healFlag_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hit_d      = 1'b0;
        healed_d   = 1'b0;
        dead_d     = dead_q;

        case (state_q)
            IDLE: begin
                index_d = '0;
                if (start && !dead_q) begin
                    dmgFlag_d  = 1'b0;
                    healFlag_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (slotDamages) dmgFlag_d = 1'b1;
                if (slotHeals)   healFlag_d = 1'b1;
                if (index_q == LAST_IDX) begin
                    state_d = APPLY;
                end else begin
                    index_d = index_q + IDX_ONE;
                end
            end
            APPLY: begin
                index_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                // Damage outranks healing; during cooldown a damaging scan
                // behaves like a plain one (heal if green, else just tick).
                if (dmgFlag_q && (cooldown_q == '0)) begin
                    hp_d       = (hp_q > DAMAGE8) ? (hp_q - DAMAGE8) : 8'd0;
                    dead_d     = (hp_q <= DAMAGE8);
                    cooldown_d = CD_RELOAD;
                    hit_d      = 1'b1;
                end else begin
                    if (healFlag_q && (hp_q < HP_MAX8)) begin
                        hp_d     = (hp_q >= (HP_MAX8 - HEAL8)) ? HP_MAX8 : (hp_q + HEAL8);
                        healed_d = 1'b1;
                    end
                    if (cooldown_q != '0) cooldown_d = cooldown_q - CD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            hp_q       <= HP_MAX8;
            cooldown_q <= '0;
            dmgFlag_q  <= 1'b0;
            healFlag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            healed_q   <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            hp_q       <= hp_d;
            cooldown_q <= cooldown_d;
            dmgFlag_q  <= dmgFlag_d;
            healFlag_q <= healFlag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            healed_q   <= healed_d;
            dead_q     <= dead_d;
        end
    end

    assign index  = index_q;
    assign hp     = hp_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign hit    = hit_q;
    assign healed = healed_q;
    assign dead   = dead_q;

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Directed bench for bullet_hit_scanner: models the bullet table as arrays
// and checks scan timing, damage/heal/cooldown rules, box edges and death.
module tb_bullet_hit_scanner;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] player_pos;
    logic [15:0] player_size;
    logic        player_moving;
    logic [2:0]  index;
    logic [15:0] bullet_position;
    logic [15:0] bullet_size;
    logic [2:0]  bullet_color;
    logic        bullet_is_render;
    logic [7:0]  hp;
    logic        busy;
    logic        done;
    logic        hit;
    logic        healed;
    logic        dead;

    logic [15:0] slotPos    [8];
    logic [15:0] slotSize   [8];
    logic [2:0]  slotColor  [8];
    logic        slotRender [8];

    int checks;
    int fails;

    bullet_hit_scanner dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .player_pos       (player_pos),
        .player_size      (player_size),
        .player_moving    (player_moving),
        .index            (index),
        .bullet_position  (bullet_position),
        .bullet_size      (bullet_size),
        .bullet_color     (bullet_color),
        .bullet_is_render (bullet_is_render),
        .hp               (hp),
        .busy             (busy),
        .done             (done),
        .hit              (hit),
        .healed           (healed),
        .dead             (dead)
    );

    // Combinational table read, as the real bullet table provides.
    assign bullet_position  = slotPos[index];
    assign bullet_size      = slotSize[index];
    assign bullet_color     = slotColor[index];
    assign bullet_is_render = slotRender[index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearScene();
        for (int i = 0; i < 8; i++) begin
            slotPos[i]    = 16'h0000;
            slotSize[i]   = 16'h0000;
            slotColor[i]  = 3'b000;
            slotRender[i] = 1'b0;
        end
        player_pos    = 16'h2020;
        player_size   = 16'h1010;
        player_moving = 1'b0;
    endtask

    task automatic setSlot(input int s, input logic [15:0] p, input logic [15:0] sz,
                           input logic [2:0] c);
        slotPos[s]    = p;
        slotSize[s]   = sz;
        slotColor[s]  = c;
        slotRender[s] = 1'b1;
    endtask

    // Pulses start and waits for done; leaves time in the cycle where done is high.
    task automatic doScan(output logic oHit, output logic oHealed,
                          output logic [7:0] oHp, output logic oDead);
        logic gotDone;
        gotDone = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                gotDone = 1'b1;
                break;
            end
        end
        checks++;
        if (gotDone !== 1'b1) begin
            fails++;
            $display("[TB] FAIL scan_done_timeout: done seen %0d, required 1", gotDone);
        end
        oHit    = hit;
        oHealed = healed;
        oHp     = hp;
        oDead   = dead;
    endtask

    task automatic coolDown();
        logic h, hl, d;
        logic [7:0] p;
        clearScene();
        for (int n = 0; n < 30; n++) doScan(h, hl, p, d);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if ({index, hp, busy, done, hit, healed, dead} !== {3'd0, 8'd20, 5'b00000}) begin
            fails++;
            $display("[TB] FAIL reset_state: index=%0d hp=%0d busy=%b done=%b hit=%b healed=%b dead=%b, required 0/20/0/0/0/0/0",
                     index, hp, busy, done, hit, healed, dead);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan_timing();
        clearScene();
        setSlot(2, 16'h2828, 16'h0404, 3'b000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (index !== 3'(i) || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("[TB] FAIL scan_step_%0d: index=%0d busy=%b done=%b, required %0d/1/0",
                         i, index, busy, done, i);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || hp !== 8'd20) begin
            fails++;
            $display("[TB] FAIL apply_cycle: busy=%b done=%b hp=%0d, required 1/0/20", busy, done, hp);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, hit, healed, busy, dead} !== 5'b11000 || hp !== 8'd16 || index !== 3'd0) begin
            fails++;
            $display("[TB] FAIL first_hit: done=%b hit=%b healed=%b busy=%b dead=%b hp=%0d index=%0d, required 1/1/0/0/0 hp 16 index 0",
                     done, hit, healed, busy, dead, hp, index);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || hit !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pulse_width: done=%b hit=%b, required 0/0", done, hit);
        end
    endtask

    task automatic test_cooldown();
        logic h, hl, d;
        logic [7:0] p;
        int lateHits;
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b0 || p !== 8'd16) begin
            fails++;
            $display("[TB] FAIL iframe_second_scan: hit=%b hp=%0d, required 0/16", h, p);
        end
        lateHits = 0;
        for (int n = 3; n <= 31; n++) begin
            doScan(h, hl, p, d);
            if (h !== 1'b0 || p !== 8'd16) lateHits++;
        end
        checks++;
        if (lateHits != 0) begin
            fails++;
            $display("[TB] FAIL iframe_window: %0d scans hit during cooldown, required 0", lateHits);
        end
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b1 || p !== 8'd12) begin
            fails++;
            $display("[TB] FAIL iframe_expired: hit=%b hp=%0d, required 1/12", h, p);
        end
    endtask

    task automatic test_colours();
        logic h, hl, d;
        logic [7:0] p;
        applyReset();
        clearScene();
        setSlot(2, 16'h2828, 16'h0404, 3'b010);
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b0 || p !== 8'd20) begin
            fails++;
            $display("[TB] FAIL blue_still: hit=%b hp=%0d, required 0/20", h, p);
        end
        slotColor[2] = 3'b111;
        player_moving = 1'b1;
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b0 || hl !== 1'b0 || p !== 8'd20) begin
            fails++;
            $display("[TB] FAIL inert_colour: hit=%b healed=%b hp=%0d, required 0/0/20", h, hl, p);
        end
        slotColor[2] = 3'b010;
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b1 || p !== 8'd16) begin
            fails++;
            $display("[TB] FAIL blue_moving: hit=%b hp=%0d, required 1/16", h, p);
        end
    endtask

    task automatic test_heal();
        logic h, hl, d;
        logic [7:0] p;
        applyReset();
        clearScene();
        setSlot(2, 16'h2828, 16'h0404, 3'b000);
        doScan(h, hl, p, d);
        slotColor[2] = 3'b001;
        for (int n = 17; n <= 20; n++) begin
            doScan(h, hl, p, d);
            checks++;
            if (hl !== 1'b1 || h !== 1'b0 || p !== 8'(n)) begin
                fails++;
                $display("[TB] FAIL heal_to_%0d: healed=%b hit=%b hp=%0d, required 1/0/%0d", n, hl, h, p, n);
            end
        end
        doScan(h, hl, p, d);
        checks++;
        if (hl !== 1'b0 || p !== 8'd20) begin
            fails++;
            $display("[TB] FAIL heal_at_max: healed=%b hp=%0d, required 0/20", hl, p);
        end
        coolDown();
        setSlot(2, 16'h2828, 16'h0404, 3'b000);
        setSlot(5, 16'h2222, 16'h0202, 3'b001);
        slotColor[2] = 3'b000;
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b1 || hl !== 1'b0 || p !== 8'd16) begin
            fails++;
            $display("[TB] FAIL white_and_green: hit=%b healed=%b hp=%0d, required 1/0/16", h, hl, p);
        end
    endtask

    task automatic test_edges();
        logic h, hl, d;
        logic [7:0] p;
        applyReset();
        clearScene();
        setSlot(0, 16'h3028, 16'h0404, 3'b000);
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b0 || p !== 8'd20) begin
            fails++;
            $display("[TB] FAIL edge_touch: hit=%b hp=%0d, required 0/20", h, p);
        end
        clearScene();
        setSlot(3, 16'h2828, 16'h0004, 3'b000);
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b0 || p !== 8'd20) begin
            fails++;
            $display("[TB] FAIL zero_width: hit=%b hp=%0d, required 0/20", h, p);
        end
        clearScene();
        setSlot(4, 16'h2828, 16'h0404, 3'b000);
        slotRender[4] = 1'b0;
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b0 || p !== 8'd20) begin
            fails++;
            $display("[TB] FAIL not_rendered: hit=%b hp=%0d, required 0/20", h, p);
        end
        clearScene();
        player_pos  = 16'hF820;
        player_size = 16'h1010;
        setSlot(7, 16'hFC28, 16'h0404, 3'b000);
        doScan(h, hl, p, d);
        checks++;
        if (h !== 1'b1 || p !== 8'd16) begin
            fails++;
            $display("[TB] FAIL no_wrap_last_slot: hit=%b hp=%0d, required 1/16", h, p);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic h, hl, d;
        logic [7:0] p;
        int sawDone;
        int waited;
        applyReset();
        clearScene();
        setSlot(2, 16'h2828, 16'h0404, 3'b000);
        doScan(h, hl, p, d);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited = 0;
        while (index !== 3'd5 && waited < 20) begin
            @(posedge clk);
            #1 waited++;
        end
        checks++;
        if (index !== 3'd5 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reach_index5: index=%0d busy=%b, required 5/1", index, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (index !== 3'd0 || hp !== 8'd20 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_scan_reset: index=%0d hp=%0d busy=%b done=%b, required 0/20/0/0",
                     index, hp, busy, done);
        end
        sawDone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) sawDone++;
        end
        checks++;
        if (sawDone != 0) begin
            fails++;
            $display("[TB] FAIL aborted_scan_resumed: %0d cycles busy/done, required 0", sawDone);
        end
    endtask

    task automatic test_death();
        logic h, hl, d;
        logic [7:0] p;
        int bad;
        applyReset();
        for (int n = 1; n <= 5; n++) begin
            clearScene();
            setSlot(2, 16'h2828, 16'h0404, 3'b000);
            doScan(h, hl, p, d);
            checks++;
            if (h !== 1'b1 || p !== 8'(20 - 4 * n) || d !== (n == 5)) begin
                fails++;
                $display("[TB] FAIL death_hit_%0d: hit=%b hp=%0d dead=%b, required 1/%0d/%0d",
                         n, h, p, d, 20 - 4 * n, n == 5);
            end
            if (n < 5) coolDown();
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy !== 1'b0 || done !== 1'b0 || hp !== 8'd0 || dead !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL dead_refuses_start: %0d bad cycles (busy=%b hp=%0d dead=%b), required 0",
                     bad, busy, hp, dead);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        start  = 1'b0;
        reset  = 1'b1;
        clearScene();
        test_reset();
        test_scan_timing();
        test_cooldown();
        test_colours();
        test_heal();
        test_edges();
        test_reset_mid_scan();
        test_death();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
